// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing the single main-memory read port among N_CPU requesters.
// One grant at a time. The grant is released on completion, on requester abort, or on watchdog timeout.
module mem_bus_arbiter #(
  parameter int unsigned N_CPU   = 2,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_CPU-1:0]         req_CPU,
  input  logic                     read_mm_completed,
  output logic [N_CPU-1:0]         gnt_CPU,
  output logic [$clog2(N_CPU)-1:0] grant_id,
  output logic                     mm_start,
  output logic                     busy,
  output logic                     timeout_err
);

  localparam int unsigned ID_W    = $clog2(N_CPU);
  localparam int unsigned WD_W    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [ID_W-1:0] ID_LAST = ID_W'(N_CPU - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_WAIT, ST_RELEASE} state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [WD_W-1:0] wdog;
  logic            done_armed;
  logic            pick_valid;
  logic [ID_W-1:0] pick_id;
  logic [ID_W-1:0] cand;

  // First requester at or above rr_ptr, wrapping modulo N_CPU.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int unsigned i = 0; i < N_CPU; i++) begin
      cand = ID_W'((32'(rr_ptr) + i) % N_CPU);
      if (!pick_valid && req_CPU[cand]) begin
        pick_valid = 1'b1;
        pick_id    = cand;
      end
    end
  end

  // Completion must be seen low at some point after the grant, so a level left over
  // from the previous transaction cannot complete the new one.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      gnt_CPU     <= '0;
      grant_id    <= '0;
      mm_start    <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      rr_ptr      <= '0;
      wdog        <= '0;
      done_armed  <= 1'b0;
    end else begin
      mm_start    <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            gnt_CPU  <= N_CPU'(1) << pick_id;
            grant_id <= pick_id;
            mm_start <= 1'b1;
            busy     <= 1'b1;
            state    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          wdog       <= '0;
          done_armed <= ~read_mm_completed;
          state      <= ST_WAIT;
        end
        ST_WAIT: begin
          // The grant drops on the exit edge; RELEASE is the bus turnaround cycle.
          if (read_mm_completed && done_armed) begin
            gnt_CPU <= '0;
            busy    <= 1'b0;
            state   <= ST_RELEASE;
          end else if (!req_CPU[grant_id]) begin
            gnt_CPU <= '0;
            busy    <= 1'b0;
            state   <= ST_RELEASE;
          end else if (TIMEOUT != 0 && wdog == WD_LAST) begin
            gnt_CPU     <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
            state       <= ST_RELEASE;
          end else begin
            if (wdog != WD_MAX) wdog <= wdog + WD_W'(1);
            if (!read_mm_completed) done_armed <= 1'b1;
          end
        end
        ST_RELEASE: begin
          gnt_CPU <= '0;
          busy    <= 1'b0;
          rr_ptr  <= (grant_id == ID_LAST) ? '0 : grant_id + ID_W'(1);
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  a_gnt_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(gnt_CPU));
  a_mm_start_in_grant: assert property (@(posedge clk) disable iff (!reset) mm_start |-> state == ST_GRANT);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a 2-CPU instance with an 8-cycle watchdog, and a 3-CPU instance for pointer wrap.
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [1:0] req;
  logic       done;
  logic [1:0] gnt;
  logic       gid;
  logic       mm_start, busy, terr;

  logic [2:0] req3;
  logic       done3;
  logic [2:0] gnt3;
  logic [1:0] gid3;
  logic       mm3, busy3, terr3;

  int vectors = 0;
  int miscompares = 0;

  mem_bus_arbiter #(.N_CPU(2), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .req_CPU(req), .read_mm_completed(done),
    .gnt_CPU(gnt), .grant_id(gid), .mm_start(mm_start), .busy(busy), .timeout_err(terr)
  );

  mem_bus_arbiter #(.N_CPU(3), .TIMEOUT(0)) dut3 (
    .clk(clk), .reset(reset), .req_CPU(req3), .read_mm_completed(done3),
    .gnt_CPU(gnt3), .grant_id(gid3), .mm_start(mm3), .busy(busy3), .timeout_err(terr3)
  );

  // Advance n rising edges; inputs and samples sit 1 time unit after each edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; req = '0; done = 1'b0; req3 = '0; done3 = 1'b0;
    step(2);
    vectors++; if (gnt !== 2'b00) begin miscompares++; $display("FAIL reset_gnt: got %b want 00", gnt); end
    vectors++; if (gid !== 1'b0) begin miscompares++; $display("FAIL reset_gid: got %0d want 0", gid); end
    vectors++; if ({mm_start, busy, terr} !== 3'b000) begin miscompares++; $display("FAIL reset_flags: got %b want 000", {mm_start, busy, terr}); end
    vectors++; if (gnt3 !== 3'b000) begin miscompares++; $display("FAIL reset_gnt3: got %b want 000", gnt3); end
    reset = 1'b1;
    step(1);
  endtask

  task automatic test_single();
    req = 2'b01;
    step(1);
    vectors++; if (gnt !== 2'b01) begin miscompares++; $display("FAIL single_gnt: got %b want 01", gnt); end
    vectors++; if ({mm_start, busy} !== 2'b11) begin miscompares++; $display("FAIL single_start: got %b want 11", {mm_start, busy}); end
    step(1);
    vectors++; if ({gnt, mm_start} !== 3'b010) begin miscompares++; $display("FAIL single_wait: got %b want 010", {gnt, mm_start}); end
    step(3);
    done = 1'b1;
    step(1);
    vectors++; if ({gnt, busy} !== 3'b000) begin miscompares++; $display("FAIL single_release: got %b want 000", {gnt, busy}); end
    done = 1'b0; req = 2'b00;
    step(2);
    vectors++; if ({gnt, gid} !== 3'b000) begin miscompares++; $display("FAIL single_idle: got %b want 000", {gnt, gid}); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_gnt [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    reset = 1'b0;
    step(1);
    reset = 1'b1; req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      step(1);
      vectors++; if (gnt !== exp_gnt[k]) begin miscompares++; $display("FAIL rr_gnt[%0d]: got %b want %b", k, gnt, exp_gnt[k]); end
      vectors++; if (gid !== 1'(k % 2)) begin miscompares++; $display("FAIL rr_gid[%0d]: got %0d want %0d", k, gid, k % 2); end
      step(3);
      done = 1'b1;
      step(1);
      vectors++; if (gnt !== 2'b00) begin miscompares++; $display("FAIL rr_release[%0d]: got %b want 00", k, gnt); end
      done = 1'b0;
      step(1);
      vectors++; if (gnt !== 2'b00) begin miscompares++; $display("FAIL rr_turnaround[%0d]: got %b want 00", k, gnt); end
    end
    req = 2'b00;
    step(2);
  endtask

  task automatic test_timeout();
    req = 2'b10;
    step(1);
    vectors++; if ({gnt, gid} !== 3'b101) begin miscompares++; $display("FAIL to_grant: got %b want 101", {gnt, gid}); end
    step(8);
    vectors++; if ({gnt, terr} !== 3'b100) begin miscompares++; $display("FAIL to_before: got %b want 100", {gnt, terr}); end
    step(1);
    vectors++; if ({gnt, terr, busy} !== 4'b0010) begin miscompares++; $display("FAIL to_fire: got %b want 0010", {gnt, terr, busy}); end
    req = 2'b11;
    step(1);
    vectors++; if (terr !== 1'b0) begin miscompares++; $display("FAIL to_pulse: got %b want 0", terr); end
    step(1);
    vectors++; if (gnt !== 2'b01) begin miscompares++; $display("FAIL to_next: got %b want 01", gnt); end
    step(1);
    done = 1'b1;
    step(1);
    vectors++; if (gnt !== 2'b00) begin miscompares++; $display("FAIL to_done: got %b want 00", gnt); end
    done = 1'b0; req = 2'b00;
    step(2);
  endtask

  task automatic test_abort();
    req = 2'b10;
    step(1);
    vectors++; if (gnt !== 2'b10) begin miscompares++; $display("FAIL ab_grant: got %b want 10", gnt); end
    step(2);
    req = 2'b00;
    step(1);
    vectors++; if ({gnt, terr, busy} !== 4'b0000) begin miscompares++; $display("FAIL ab_release: got %b want 0000", {gnt, terr, busy}); end
    req = 2'b11;
    step(1);
    vectors++; if ({gnt, terr} !== 3'b000) begin miscompares++; $display("FAIL ab_turnaround: got %b want 000", {gnt, terr}); end
    step(1);
    vectors++; if (gnt !== 2'b01) begin miscompares++; $display("FAIL ab_ptr: got %b want 01", gnt); end
    step(1);
    done = 1'b1;
    step(1);
    done = 1'b0; req = 2'b00;
    step(2);
  endtask

  task automatic test_done_abort();
    req = 2'b10;
    step(3);
    done = 1'b1; req = 2'b00;
    step(1);
    vectors++; if ({gnt, terr} !== 3'b000) begin miscompares++; $display("FAIL da_release: got %b want 000", {gnt, terr}); end
    req = 2'b01;
    step(2);
    vectors++; if ({gnt, mm_start} !== 3'b011) begin miscompares++; $display("FAIL da_grant: got %b want 011", {gnt, mm_start}); end
    step(3);
    vectors++; if ({gnt, busy} !== 3'b011) begin miscompares++; $display("FAIL da_stuck_done: got %b want 011", {gnt, busy}); end
    req = 2'b00;
    step(1);
    vectors++; if ({gnt, terr} !== 3'b000) begin miscompares++; $display("FAIL da_abort: got %b want 000", {gnt, terr}); end
    done = 1'b0;
    step(2);
  endtask

  task automatic test_reset_mid();
    req = 2'b10;
    step(1);
    vectors++; if (gnt !== 2'b10) begin miscompares++; $display("FAIL rm_grant: got %b want 10", gnt); end
    step(2);
    reset = 1'b0; req = 2'b11;
    step(1);
    vectors++; if ({gnt, gid, mm_start, busy, terr} !== 6'b000000) begin miscompares++; $display("FAIL rm_outputs: got %b want 000000", {gnt, gid, mm_start, busy, terr}); end
    reset = 1'b1;
    step(1);
    vectors++; if ({gnt, gid} !== 3'b010) begin miscompares++; $display("FAIL rm_ptr: got %b want 010", {gnt, gid}); end
    req = 2'b00;
    step(3);
  endtask

  task automatic test_wrap3();
    req3 = 3'b010;
    step(1);
    vectors++; if ({gnt3, gid3} !== 5'b01001) begin miscompares++; $display("FAIL w3_cpu1: got %b want 01001", {gnt3, gid3}); end
    step(1);
    done3 = 1'b1;
    step(1);
    vectors++; if (gnt3 !== 3'b000) begin miscompares++; $display("FAIL w3_release: got %b want 000", gnt3); end
    req3 = 3'b011; done3 = 1'b0;
    step(2);
    vectors++; if ({gnt3, gid3} !== 5'b00100) begin miscompares++; $display("FAIL w3_from_ptr2: got %b want 00100", {gnt3, gid3}); end
    step(1);
    done3 = 1'b1;
    step(1);
    req3 = 3'b100; done3 = 1'b0;
    step(2);
    vectors++; if ({gnt3, gid3} !== 5'b10010) begin miscompares++; $display("FAIL w3_cpu2: got %b want 10010", {gnt3, gid3}); end
    step(1);
    done3 = 1'b1;
    step(1);
    req3 = 3'b011; done3 = 1'b0;
    step(2);
    vectors++; if ({gnt3, gid3} !== 5'b00100) begin miscompares++; $display("FAIL w3_ptr_wrap: got %b want 00100", {gnt3, gid3}); end
    req3 = 3'b000;
    step(3);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_abort();
    test_done_abort();
    test_reset_mid();
    test_wrap3();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
